// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: strips the trailing 4-byte FCS through a delay line and
// flags each frame for CRC-32 residue and length, with good/bad frame counters.
module eth_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk50,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_eop,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_eop,
  output logic        out_crc_ok,
  output logic        out_len_ok,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
  localparam logic [10:0] CntMax     = 11'd2047;

  typedef enum logic [1:0] {StIdle, StFill, StPass} state_e;

  state_e      state_q;
  logic [31:0] dly_q;
  logic [10:0] cnt_q;
  logic [31:0] crc_q;
  logic        pend_q;
  logic        pend_crc_q;
  logic        pend_len_q;

  logic [31:0] crc_seed;
  logic [31:0] crc_nx;
  logic [10:0] cnt_nx;
  logic        frame_end;
  logic        emit;
  logic        end_crc_ok;
  logic        end_len_ok;
  logic        fire;
  logic        fire_crc;
  logic        fire_len;
  logic        pend_d;
  logic        pend_crc_d;
  logic        pend_len_d;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_seed = (state_q == StIdle) ? CrcInit : crc_q;
    crc_nx   = in_valid ? crc_byte(crc_seed, in_data) : crc_q;
    if (!in_valid) begin
      cnt_nx = cnt_q;
    end else if (state_q == StIdle) begin
      cnt_nx = 11'd1;
    end else if (cnt_q == CntMax) begin
      cnt_nx = CntMax;
    end else begin
      cnt_nx = cnt_q + 11'd1;
    end
    frame_end  = in_eop && ((state_q != StIdle) || in_valid);
    emit       = in_valid && (state_q == StPass);
    end_crc_ok = (crc_nx == CrcResidue) && (cnt_nx >= 11'd4);
    end_len_ok = ({21'd0, cnt_nx} >= MIN_LEN) && ({21'd0, cnt_nx} <= MAX_LEN);
  end

  // A frame ending on a byte that also releases payload cannot raise out_eop beside
  // out_valid, so its end-of-frame is parked one cycle in the pending slot.
  always_comb begin
    fire       = 1'b0;
    fire_crc   = 1'b0;
    fire_len   = 1'b0;
    pend_d     = pend_q;
    pend_crc_d = pend_crc_q;
    pend_len_d = pend_len_q;
    if (emit) begin
      if (frame_end) begin
        pend_d     = 1'b1;
        pend_crc_d = end_crc_ok;
        pend_len_d = end_len_ok;
      end
    end else if (pend_q) begin
      fire       = 1'b1;
      fire_crc   = pend_crc_q;
      fire_len   = pend_len_q;
      pend_d     = frame_end;
      pend_crc_d = end_crc_ok;
      pend_len_d = end_len_ok;
    end else if (frame_end) begin
      fire     = 1'b1;
      fire_crc = end_crc_ok;
      fire_len = end_len_ok;
    end
  end

  always_ff @(posedge clk50 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      dly_q      <= 32'h0;
      cnt_q      <= 11'd0;
      crc_q      <= CrcInit;
      pend_q     <= 1'b0;
      pend_crc_q <= 1'b0;
      pend_len_q <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_eop    <= 1'b0;
      out_crc_ok <= 1'b0;
      out_len_ok <= 1'b0;
      good_count <= 16'h0;
      bad_count  <= 16'h0;
    end else begin
      if (in_valid) begin
        crc_q <= crc_nx;
        cnt_q <= cnt_nx;
        dly_q <= {dly_q[23:0], in_data};
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid && !in_eop) state_q <= StFill;
        end
        StFill: begin
          if (in_eop) begin
            state_q <= StIdle;
          end else if (in_valid && (cnt_nx == 11'd4)) begin
            state_q <= StPass;
          end
        end
        StPass: begin
          if (in_eop) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      out_valid <= emit;
      out_data  <= emit ? dly_q[31:24] : 8'h00;

      pend_q     <= pend_d;
      pend_crc_q <= pend_crc_d;
      pend_len_q <= pend_len_d;
      out_eop    <= fire;
      out_crc_ok <= fire && fire_crc;
      out_len_ok <= fire && fire_len;
      if (fire) begin
        if (fire_crc && fire_len) begin
          good_count <= good_count + 16'd1;
        end else begin
          bad_count <= bad_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: known-FCS frames, corrupt, short, back-to-back,
// same-cycle end-of-frame and mid-frame reset, with per-cycle qualifier checks.
module tb_eth_rx_fcs_check;

  logic        clk50;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_eop;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_eop;
  logic        out_crc_ok;
  logic        out_len_ok;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       eop_crc[$];
  logic       eop_len[$];

  eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk50      (clk50),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_eop     (in_eop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_eop    (out_eop),
    .out_crc_ok (out_crc_ok),
    .out_len_ok (out_len_ok),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk50) begin
    chk("qualifiers", {29'd0, out_valid & out_eop, !out_valid && (out_data != 8'h00),
        !out_eop && (out_crc_ok || out_len_ok)}, 32'd0);
    if (out_valid) rx_q.push_back(out_data);
    if (out_eop) begin
      eop_crc.push_back(out_crc_ok);
      eop_len.push_back(out_len_ok);
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    eop_crc.delete();
    eop_len.delete();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_eop   = 1'b0;
    in_data  = 8'h00;
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic send_frame(input bit eop_with_last);
    for (int i = 0; i < tx.size(); i++) begin
      in_data  = tx[i];
      in_valid = 1'b1;
      in_eop   = eop_with_last && (i == tx.size() - 1);
      @(posedge clk50);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (!eop_with_last) begin
      in_eop = 1'b1;
      @(posedge clk50);
      #1;
    end
    in_eop = 1'b0;
  endtask

  // Standard Ethernet FCS over tx, appended LSB first.
  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < tx.size(); i++) begin
      c = c ^ {24'h0, tx[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    tx.push_back(c[7:0]);
    tx.push_back(c[15:8]);
    tx.push_back(c[23:16]);
    tx.push_back(c[31:24]);
  endtask

  task automatic build_zero_frame();
    tx.delete();
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      tx.push_back(8'h00);
      exp_q.push_back(8'h00);
    end
    append_fcs();
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic check_eop(input string tag, input int idx, input bit crc, input bit len);
    if (idx < eop_crc.size()) begin
      chk({tag, "_crc_ok"}, {31'd0, eop_crc[idx]}, {31'd0, crc});
      chk({tag, "_len_ok"}, {31'd0, eop_len[idx]}, {31'd0, len});
    end else begin
      chk({tag, "_eop_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_eop   = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_good", {16'd0, good_count}, 32'd0);
    chk("rst_bad", {16'd0, bad_count}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // "123456789" + FCS 26 39 F4 CB: CRC good, too short
    clear_mon();
    tx = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(1'b0);
    idle(3);
    check_rx("ascii");
    chk("ascii_neops", eop_crc.size(), 32'd1);
    check_eop("ascii", 0, 1'b1, 1'b0);
    chk("ascii_bad", {16'd0, bad_count}, 32'd1);
    chk("ascii_good", {16'd0, good_count}, 32'd0);

    // 64-byte good frame
    clear_mon();
    build_zero_frame();
    send_frame(1'b0);
    idle(3);
    check_rx("zero");
    chk("zero_neops", eop_crc.size(), 32'd1);
    check_eop("zero", 0, 1'b1, 1'b1);
    chk("zero_good", {16'd0, good_count}, 32'd1);

    // Corrupted payload byte, original FCS kept
    clear_mon();
    build_zero_frame();
    tx[10] = tx[10] ^ 8'h01;
    exp_q[10] = 8'h01;
    send_frame(1'b0);
    idle(3);
    check_rx("corrupt");
    check_eop("corrupt", 0, 1'b0, 1'b1);
    chk("corrupt_bad", {16'd0, bad_count}, 32'd2);
    chk("corrupt_good", {16'd0, good_count}, 32'd1);

    // 3-byte runt
    clear_mon();
    tx = '{8'hAA, 8'hBB, 8'hCC};
    exp_q.delete();
    send_frame(1'b0);
    idle(3);
    check_rx("runt");
    chk("runt_neops", eop_crc.size(), 32'd1);
    check_eop("runt", 0, 1'b0, 1'b0);
    chk("runt_bad", {16'd0, bad_count}, 32'd3);

    // in_eop alone while idle is ignored
    clear_mon();
    in_eop = 1'b1;
    @(posedge clk50);
    #1;
    idle(3);
    chk("lone_eop_neops", eop_crc.size(), 32'd0);
    chk("lone_eop_good", {16'd0, good_count}, 32'd1);
    chk("lone_eop_bad", {16'd0, bad_count}, 32'd3);

    // Two good frames back to back
    clear_mon();
    build_zero_frame();
    send_frame(1'b0);
    send_frame(1'b0);
    for (int i = 0; i < 60; i++) exp_q.push_back(8'h00);
    idle(3);
    check_rx("b2b");
    chk("b2b_neops", eop_crc.size(), 32'd2);
    check_eop("b2b_first", 0, 1'b1, 1'b1);
    check_eop("b2b_second", 1, 1'b1, 1'b1);
    chk("b2b_good", {16'd0, good_count}, 32'd3);

    // eop on the last byte, then a 1-byte frame ending in its only cycle
    clear_mon();
    build_zero_frame();
    send_frame(1'b1);
    tx = '{8'h55};
    send_frame(1'b1);
    idle(4);
    check_rx("same_cycle");
    chk("same_cycle_neops", eop_crc.size(), 32'd2);
    check_eop("same_cycle_good", 0, 1'b1, 1'b1);
    check_eop("one_byte", 1, 1'b0, 1'b0);
    chk("same_cycle_good", {16'd0, good_count}, 32'd4);
    chk("same_cycle_bad", {16'd0, bad_count}, 32'd4);

    // Reset after byte 20 of a frame, then a good frame
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      in_data  = 8'h00;
      in_valid = 1'b1;
      @(posedge clk50);
      #1;
    end
    in_valid = 1'b0;
    rstn     = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_good", {16'd0, good_count}, 32'd0);
    chk("midrst_bad", {16'd0, bad_count}, 32'd0);
    rstn = 1'b1;
    idle(3);
    chk("midrst_no_eop", eop_crc.size(), 32'd0);
    clear_mon();
    build_zero_frame();
    send_frame(1'b0);
    idle(3);
    check_rx("after_rst");
    chk("after_rst_neops", eop_crc.size(), 32'd1);
    check_eop("after_rst", 0, 1'b1, 1'b1);
    chk("after_rst_good", {16'd0, good_count}, 32'd1);
    chk("after_rst_bad", {16'd0, bad_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_fcs_check.md
ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes, FCS included.
REQ-002 Parameter MAX_LEN, default 1518, maximum legal frame length in bytes, FCS included.
REQ-003 clk50  input  1  single clock; all logic on posedge clk50.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  8  received byte from the RMII receiver.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_eop  input  1  end-of-frame pulse.
REQ-008 out_data  output  8  payload byte to the packet buffer, FCS stripped.
REQ-009 out_valid  output  1  out_data valid this cycle.
REQ-010 out_eop  output  1  one-cycle end-of-frame pulse.
REQ-011 out_crc_ok  output  1  FCS correct; valid only while out_eop=1.
REQ-012 out_len_ok  output  1  length within MIN_LEN..MAX_LEN; valid only while out_eop=1.
REQ-013 good_count  output  16  frames ended with crc_ok and len_ok both 1.
REQ-014 bad_count  output  16  frames ended with either flag 0.

Function
REQ-015 The block SHALL hold a 4-byte delay line, an 11-bit byte counter, a 32-bit CRC register and a state machine with states IDLE, FILL and PASS.
REQ-016 IDLE: on in_valid, the block SHALL load the CRC with 0xFFFFFFFF, update it with the byte, set the count to 1, store the byte in the delay line and enter FILL.
REQ-017 FILL: while fewer than 4 bytes are held, each in_valid SHALL store the byte with no output; the 4th byte SHALL cause a move to PASS.
REQ-018 PASS: each in_valid SHALL drive the oldest held byte on out_data with out_valid=1 on the next cycle, then shift the new byte in.
REQ-019 The CRC SHALL be reflected CRC-32 (polynomial 0xEDB88320, byte processed LSB first, one byte per cycle) over every input byte, FCS included.
REQ-020 The byte counter SHALL count every input byte and saturate at 2047.
REQ-021 On in_eop, the block SHALL pulse out_eop on the next cycle and return to IDLE; held bytes, which are the FCS, SHALL be discarded.
REQ-022 out_crc_ok SHALL be 1 only when the CRC register, with the last byte included, equals 0xDEBB20E3 and the count is at least 4.
REQ-023 out_len_ok SHALL be 1 only when MIN_LEN <= count <= MAX_LEN.
REQ-024 When in_valid and in_eop are both high in the same cycle, the byte SHALL be processed first, then the frame SHALL end in that same cycle with flags covering that byte.
REQ-025 in_eop in IDLE, with no bytes received, SHALL be ignored: no out_eop and no counter change.
REQ-026 A frame of 1-3 bytes SHALL produce no out_valid, then out_eop with both flags 0.
REQ-027 in_valid in the cycle after in_eop SHALL start a new frame with no lost byte.
REQ-028 out_valid and out_eop SHALL never be high in the same cycle.
REQ-029 At out_eop, exactly one of good_count and bad_count SHALL increment; both SHALL wrap modulo 2^16.
REQ-030 out_data, out_crc_ok and out_len_ok SHALL be 0 in every cycle where their qualifier (out_valid or out_eop) is low.

Reset
REQ-031 rstn low SHALL immediately force the state to IDLE, all outputs and counters to 0, the delay line and byte count to 0, and the CRC to 0xFFFFFFFF.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no out_eop; after release, bytes SHALL be treated as a new frame starting at the next in_valid.

Verification
REQ-033 Bytes "123456789", then 26 39 F4 CB, then in_eop -> 9 out bytes 0x31..0x39, then out_eop with crc_ok=1, len_ok=0, bad_count=1.
REQ-034 60 bytes of 0x00 with correct FCS (64 bytes) -> 60 out bytes of 0x00, out_eop with crc_ok=1, len_ok=1, good_count=1.
REQ-035 Same 64-byte frame with byte 10 XORed with 0x01 -> out_eop with crc_ok=0, len_ok=1, bad_count increments.
REQ-036 3-byte frame AA BB CC then in_eop -> no out_valid, out_eop with both flags 0; in_eop alone in IDLE -> no response.
REQ-037 Two good frames, the second starting the cycle after the first in_eop -> both fully output, good_count=2.
REQ-038 rstn pulsed after byte 20 of a frame, then a good 64-byte frame -> no out_eop for the aborted frame, good frame passes, good_count=1.
